// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: opcode constants, FSM states
// and the default datapath width.
package alu_pkg;

    localparam int DW_DEFAULT = 32;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_INC = 4'b1101;
    localparam logic [3:0] OP_DEC = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Command and response channels of the ALU operand sequencer.
// The master issues commands and consumes responses; the sequencer is the slave.
interface alu_seq_if #(
    parameter int DW = alu_pkg::DW_DEFAULT,
    parameter int AW = 3
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_rd;
    logic [DW-1:0] rsp_result;
    logic          rsp_cout;
    logic          rsp_overflow;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rd, rsp_result, rsp_cout, rsp_overflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rd, rsp_result, rsp_cout, rsp_overflow
    );

endinterface

// File: rtl/alu_seq_rf.sv
// Register file with two registered read ports (values hold between reads) and
// two write ports; a writeback beats a load to the same entry in the same cycle.
module alu_seq_rf
    import alu_pkg::*;
#(
    parameter int  DW       = DW_DEFAULT,
    parameter int  RF_DEPTH = 8,
    localparam int AW       = $clog2(RF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    logic [DW-1:0] mem_q [RF_DEPTH];
    logic [DW-1:0] mem_d [RF_DEPTH];
    logic [DW-1:0] rd_data1_q, rd_data1_d;
    logic [DW-1:0] rd_data2_q, rd_data2_d;

    // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d      = mem_q;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        if (ld_en) mem_d[ld_addr] = ld_data;
        if (wb_en) mem_d[wb_addr] = wb_data;
        // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
        if (rd_en) begin
            rd_data1_d = mem_q[rd_addr1];
            rd_data2_d = mem_q[rd_addr2];
        end
    end

    // NOTE: the array is small and architecturally cleared, so it is reset like any other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;

endmodule

// File: rtl/alu_seq.sv
// Operand sequencer in front of the ALU: accept, issue for one cycle, write back, respond.
// Optional macro ALU_SEQ_STICKY_FLAGS_EN adds sticky carry/overflow flags with flag_clr.
module alu_seq
    import alu_pkg::*;
#(
    parameter int  DW       = DW_DEFAULT,
    parameter int  RF_DEPTH = 8,
    localparam int AW       = $clog2(RF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_if.slave      bus,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          alu_status,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_cout,
    input  logic          alu_overflow
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   ,input  logic          flag_clr,
    output logic          flag_c,
    output logic          flag_v
`endif
);

    state_e        state_q, state_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rsp_rd_q, rsp_rd_d;
    logic [DW-1:0] rsp_result_q, rsp_result_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic          accept;
    logic          wb_en;

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_result_d  = rsp_result_q;
        rsp_cout_d    = rsp_cout_q;
        rsp_ovf_d     = rsp_ovf_q;
        accept        = 1'b0;
        wb_en         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_status    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = !rst;
                if (bus.cmd_valid && !rst) begin
                    accept   = 1'b1;
                    opcode_d = bus.cmd_op;
                    rd_d     = bus.cmd_rd;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                alu_status   = !rst;
                wb_en        = 1'b1;
                rsp_rd_d     = rd_q;
                rsp_result_d = alu_result;
                rsp_cout_d   = alu_cout;
                rsp_ovf_d    = alu_overflow;
                state_d      = RESP;
            end
            RESP: begin
                bus.rsp_valid = !rst;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opcode_q     <= '0;
            rd_q         <= '0;
            rsp_rd_q     <= '0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            rd_q         <= rd_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    // The read-port registers double as the held alu_a/alu_b operand registers.
    alu_seq_rf #(.DW(DW), .RF_DEPTH(RF_DEPTH)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept),
        .rd_addr1 (bus.cmd_rs1),
        .rd_addr2 (bus.cmd_rs2),
        .rd_data1 (alu_a),
        .rd_data2 (alu_b),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (alu_result),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    assign alu_opcode       = opcode_q;
    assign bus.rsp_rd       = rsp_rd_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_cout     = rsp_cout_q;
    assign bus.rsp_overflow = rsp_ovf_q;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic flag_c_q, flag_c_d;
    logic flag_v_q, flag_v_d;

    always_comb begin
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        if (wb_en) begin
            flag_c_d = flag_c_q | alu_cout;
            flag_v_d = flag_v_q | alu_overflow;
        end
        if (flag_clr) begin
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`else
    // Without sticky flags, carry/overflow are reported only through the response.
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a behavioural ALU plus a register-file model
// predict every operand, response and writeback; random and directed commands.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int DW       = 32;
    localparam int RF_DEPTH = 8;
    localparam int AW       = 3;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
    } alu_out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.DW(DW), .AW(AW)) bus ();

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          alu_status;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          alu_cout, alu_overflow;
    alu_out_t      alu_o;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic flag_clr, flag_c, flag_v;
`endif

    alu_seq #(.DW(DW), .RF_DEPTH(RF_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_status   (alu_status),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
       ,.flag_clr     (flag_clr),
        .flag_c       (flag_c),
        .flag_v       (flag_v)
`endif
    );

    // Behavioural ALU: plain 32-bit arithmetic, silent when not enabled.
    function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        alu_out_t    o;
        logic [32:0] s;
        o = '0;
        s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                o.r = s[31:0]; o.c = s[32];
                o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.r = s[31:0]; o.c = s[32];
                o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
            end
            OP_INC: begin
                s = {1'b0, a} + 33'd1;
                o.r = s[31:0]; o.c = s[32]; o.v = (a == 32'h7FFF_FFFF);
            end
            OP_DEC: begin
                s = {1'b0, a} + 33'h0_FFFF_FFFF;
                o.r = s[31:0]; o.c = s[32]; o.v = (a == 32'h8000_0000);
            end
            OP_AND:  o.r = a & b;
            OP_OR:   o.r = a | b;
            OP_XOR:  o.r = a ^ b;
            OP_NOT:  o.r = ~a;
            default: o = '0;
        endcase
        return o;
    endfunction

    assign alu_o        = alu_status ? alu_fn(alu_opcode, alu_a, alu_b) : '0;
    assign alu_result   = alu_o.r;
    assign alu_cout     = alu_o.c;
    assign alu_overflow = alu_o.v;

    logic [31:0] model_rf [RF_DEPTH];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] op_pool [10] = '{OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
                                 OP_XOR, OP_NOT, 4'b0000, 4'b1010};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int addr, input logic [31:0] data);
        ld_en = 1'b1; ld_addr = AW'(addr); ld_data = data;
        step();
        ld_en = 1'b0;
        model_rf[addr] = data;
    endtask

    // ld_phase: 0 none, 1 load during the accept cycle, 2 load during the writeback cycle.
    task automatic run_cmd(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                           input int stall, input int ld_phase, input int ld_a,
                           input logic [31:0] ld_d, output logic [31:0] got_res,
                           output logic got_c, output int acc_cyc);
        alu_out_t    e;
        logic [31:0] a, b;
        check("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_rd = AW'(rd); bus.cmd_rs1 = AW'(rs1); bus.cmd_rs2 = AW'(rs2);
        a = model_rf[rs1];
        b = model_rf[rs2];
        e = alu_fn(op, a, b);
        if (ld_phase == 1) begin
            ld_en = 1'b1; ld_addr = AW'(ld_a); ld_data = ld_d;
        end
        step();
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        ld_en = 1'b0;
        if (ld_phase == 1) model_rf[ld_a] = ld_d;
        check("issue_status", alu_status, 1);
        check("issue_opcode", alu_opcode, op);
        check("issue_a", alu_a, a);
        check("issue_b", alu_b, b);
        check("issue_cmd_ready", bus.cmd_ready, 0);
        check("issue_rsp_valid", bus.rsp_valid, 0);
        if (ld_phase == 2) begin
            ld_en = 1'b1; ld_addr = AW'(ld_a); ld_data = ld_d;
        end
        bus.rsp_ready = (stall == 0);
        step();
        ld_en = 1'b0;
        if (ld_phase == 2 && ld_a != rd) model_rf[ld_a] = ld_d;
        model_rf[rd] = e.r;
        got_res = bus.rsp_result;
        got_c   = bus.rsp_cout;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_rd", bus.rsp_rd, rd);
        check("rsp_result", bus.rsp_result, e.r);
        check("rsp_cout", bus.rsp_cout, e.c);
        check("rsp_overflow", bus.rsp_overflow, e.v);
        check("rsp_status_low", alu_status, 0);
        check("rsp_cmd_ready", bus.cmd_ready, 0);
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_rd", bus.rsp_rd, rd);
            check("stall_result", bus.rsp_result, e.r);
            check("stall_cout", bus.rsp_cout, e.c);
            check("stall_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_status"}, alu_status, 0);
        check({tag, "_opcode"}, alu_opcode, 0);
        check({tag, "_a"}, alu_a, 0);
        check({tag, "_b"}, alu_b, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rd"}, bus.rsp_rd, 0);
        check({tag, "_rsp_result"}, bus.rsp_result, 0);
        check({tag, "_rsp_cout"}, bus.rsp_cout, 0);
        check({tag, "_rsp_ovf"}, bus.rsp_overflow, 0);
    endtask

    initial begin
        logic [31:0] res;
        logic        c;
        int          acc, prev_acc;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0;
        bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        for (int i = 0; i < RF_DEPTH; i++) model_rf[i] = '0;

        #1;
        check("reset_cmd_ready", bus.cmd_ready, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("por");

        // add r3 = r1 + r2, then read r3 back through an OR
        do_load(1, 32'h0000_0005);
        do_load(2, 32'h0000_0003);
        run_cmd(OP_ADD, 3, 1, 2, 0, 0, 0, '0, res, c, acc);
        check("tp_add_result", res, 32'h8);
        check("tp_add_cout", c, 0);
        run_cmd(OP_OR, 3, 3, 3, 0, 0, 0, '0, res, c, acc);
        check("tp_r3_readback", res, 32'h8);

        // inc wraps with carry out
        do_load(1, 32'hFFFF_FFFF);
        run_cmd(OP_INC, 4, 1, 1, 0, 0, 0, '0, res, c, acc);
        check("tp_inc_result", res, 32'h0);
        check("tp_inc_cout", c, 1);

        // sub with a 5-cycle response stall
        run_cmd(OP_SUB, 6, 3, 2, 5, 0, 0, '0, res, c, acc);
        check("tp_sub_result", res, 32'h5);

        // writeback beats a same-cycle load; different addresses both land
        run_cmd(OP_ADD, 5, 2, 2, 0, 2, 5, 32'hDEAD_BEEF, res, c, acc);
        run_cmd(OP_OR, 7, 5, 5, 0, 0, 0, '0, res, c, acc);
        check("tp_wb_wins", res, 32'h6);
        run_cmd(OP_ADD, 5, 2, 2, 0, 2, 6, 32'hDEAD_BEEF, res, c, acc);
        run_cmd(OP_OR, 7, 6, 6, 0, 0, 0, '0, res, c, acc);
        check("tp_ld_other", res, 32'hDEAD_BEEF);

        // load during acceptance to rs1 is not seen by the operand read
        run_cmd(OP_OR, 0, 2, 2, 0, 1, 2, 32'h0000_00F0, res, c, acc);
        check("tp_old_operand", res, 32'h3);

        // rs1 == rs2 == rd doubles the register
        run_cmd(OP_ADD, 3, 3, 3, 0, 0, 0, '0, res, c, acc);
        check("tp_double", res, 32'h10);

        // undefined opcode issues and writes back zero
        do_load(1, 32'h0000_1234);
        run_cmd(4'b0000, 2, 1, 1, 0, 0, 0, '0, res, c, acc);
        check("tp_op0000", res, 32'h0);

        // back-to-back with rsp_ready high: one accept every 3 cycles
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            run_cmd(OP_XOR, i, i + 1, i + 2, 0, 0, 0, '0, res, c, acc);
            if (i > 0) check("throughput", acc - prev_acc, 3);
            prev_acc = acc;
        end

        // reset while in ISSUE aborts the command
        do_load(1, 32'h1111_0000);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD;
        bus.cmd_rd = 3'd4; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd1;
        step();
        bus.cmd_valid = 1'b0;
        check("abort_in_issue", alu_status, 1);
        rst = 1'b1;
        #1;
        check("abort_cmd_ready", bus.cmd_ready, 0);
        check("abort_status", alu_status, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < RF_DEPTH; i++) model_rf[i] = '0;
        check_reset_outputs("abort");
        step();
        check("abort_rsp_stays_low", bus.rsp_valid, 0);
        run_cmd(OP_OR, 4, 4, 1, 0, 0, 0, '0, res, c, acc);
        check("abort_no_wb", res, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, RF_DEPTH - 1), $urandom);
            run_cmd(op_pool[$urandom_range(0, 9)], $urandom_range(0, RF_DEPTH - 1),
                    $urandom_range(0, RF_DEPTH - 1), $urandom_range(0, RF_DEPTH - 1),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, RF_DEPTH - 1), $urandom, res, c, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command-driven operand sequencer sitting directly upstream of the 32-bit ALU. It accepts ALU commands over a valid/ready handshake and reads two source operands from an internal register file. It drives the ALU's status/opcode/a/b inputs for one cycle, captures result/cout/overflow, writes the result back to the destination register and presents a response. It is the only driver of the ALU inputs.

## Interface
- DW, 32, datapath width; must match ALU width
- RF_DEPTH, 8, register-file entries; power of two, >= 2
- AW, $clog2(RF_DEPTH), register index width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_op  in  4  ALU opcode
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  source for ALU a
- cmd_rs2  in  AW  source for ALU b
- ld_en  in  1  direct register load strobe
- ld_addr  in  AW  load target
- ld_data  in  DW  load value
- alu_status  out  1  ALU enable
- alu_opcode  out  4  to ALU opcode
- alu_a  out  DW  to ALU a
- alu_b  out  DW  to ALU b
- alu_result  in  DW  from ALU result (combinational)
- alu_cout  in  1  from ALU cout
- alu_overflow  in  1  from ALU overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rd  out  AW  destination written
- rsp_result  out  DW  captured result
- rsp_cout  out  1  captured carry
- rsp_overflow  out  1  captured overflow

## Operation
- Opcodes forwarded unmodified: 1111 add, 1110 sub, 1101 inc, 1100 dec, 0111 and, 0110 or, 0101 xor, 0100 not; other codes are still issued (the ALU returns 0) and are written back.
- FSM states IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1; on cmd_valid: latch op/rd; read rf[rs1], rf[rs2] into alu_a/alu_b registers; go to ISSUE.
- ISSUE: alu_status=1; at the cycle end, write rf[rd] <= alu_result and register rsp_* from the ALU outputs; go to RESP.
- RESP: rsp_valid=1; fields held stable until rsp_ready; on rsp_ready go to IDLE.
- alu_status=0 in IDLE and RESP. alu_a/alu_b/alu_opcode hold their last values.
- Operand read happens at acceptance. A same-cycle ld_en to rs1/rs2 is not seen; the old value is used.
- Load port is active in any state. If a load and a writeback hit the same address in the same cycle, the writeback wins and the load is dropped. Different addresses both complete.
- rs1==rs2==rd is legal; for example, add r3,r3,r3 doubles r3.

## Timing
- Acceptance at edge T; ALU driven during T+1; rsp_valid first high in T+2; rf[rd] updated at edge T+2.
- Minimum 3 cycles per command. cmd_ready is low from T+1 until the cycle after the rsp handshake.
- rsp_ready held high gives back-to-back throughput of 1 command per 3 cycles.
- Reset (all outputs and state): state IDLE, all rf entries 0, cmd_ready=0 during the reset cycle then 1, alu_status=0, alu_opcode=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_rd=0, rsp_result=0, rsp_cout=0, rsp_overflow=0.
- Reset mid-operation (ISSUE or RESP): command aborted, no writeback, pending response discarded.

## Configuration
- ALU_SEQ_STICKY_FLAGS_EN defined: adds outputs flag_c and flag_v. These are sticky OR of every captured cout/overflow, and flag_clr (input) clears them. Clear has priority over a same-cycle set. Both reset to 0.
- ALU_SEQ_STICKY_FLAGS_EN undefined: flag ports and registers absent; behaviour otherwise identical.

## Structure
- Shared package alu_pkg holds the opcode constants (OP_ADD..OP_NOT), the FSM state enum, and DW default.
- One sub-module, alu_seq_rf: RF_DEPTH x DW register file with two registered read ports and two write ports (writeback, load) resolved by the stated priority.

## Test plan
- Load r1=0x0000_0005, r2=0x0000_0003; cmd 1111 rd=3 rs1=1 rs2=2 -> rsp_valid at T+2, rsp_result=0x8, rsp_cout=0, r3=0x8.
- Load r1=0xFFFF_FFFF; cmd 1101 (inc) rd=4 rs1=1 -> rsp_result=0x0, rsp_cout=1, r4=0.
- Cmd 1110 with rsp_ready low for 5 cycles -> rsp fields stable, cmd_ready=0 throughout, one accept after release.
- Writeback to r5 with a same-cycle ld_en r5=0xDEAD_BEEF -> r5 holds the ALU result; a repeat with ld_addr=r6 writes both.
- rst asserted in ISSUE -> no rf write, rsp_valid stays 0, all outputs at reset values the next cycle.
- Opcode 0000 with r1=0x1234 -> alu_status=1 for one cycle, rsp_result=0, rd written 0.
